// File: rtl/rx_write_scheduler.sv
// RDMA WRITE receive scheduler: queues parsed headers and splits each message into credit-limited
// DataMover S2MM commands. Define RX_RKEY_CHECK_EN to validate rkey against local_rkey.
module rx_write_scheduler #(
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_BTT_WIDTH       = 23,
  parameter int RDMA_LENGTH_WIDTH = 32,
  parameter int RDMA_ADDR_WIDTH   = 64,
  parameter int RDMA_RKEY_WIDTH   = 32,
  parameter int OFFSET_LENGTH     = 16,
  parameter int HDR_FIFO_DEPTH    = 8,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int MAX_BURST_BYTES   = 4096,
  parameter logic [4:0][7:0] WRITE_OPCODES = {8'h06, 8'h07, 8'h08, 8'h0A, 8'h01}
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         header_valid,
  input  logic [7:0]                   rdma_opcode,
  input  logic [RDMA_ADDR_WIDTH-1:0]   rdma_remote_addr,
  input  logic [RDMA_RKEY_WIDTH-1:0]   rdma_rkey,
  input  logic [RDMA_LENGTH_WIDTH-1:0] rdma_length,
  input  logic [OFFSET_LENGTH-1:0]     fragment_offset,
  input  logic [RDMA_RKEY_WIDTH-1:0]   local_rkey,
  output logic [C_ADDR_WIDTH+39:0]     m_axis_s2mm_cmd_tdata,
  output logic                         m_axis_s2mm_cmd_tvalid,
  input  logic                         m_axis_s2mm_cmd_tready,
  input  logic                         s2mm_wr_xfer_cmplt,
  output logic [1:0]                   rx_state,
  output logic                         rx_active,
  output logic [3:0]                   outstanding,
  output logic                         write_accepted,
  output logic                         write_complete,
  output logic                         hdr_dropped,
  output logic                         hdr_overflow,
  output logic                         rkey_error
);

  localparam int FIFO_AW = $clog2(HDR_FIFO_DEPTH);
  localparam logic [RDMA_LENGTH_WIDTH-1:0] MAX_BURST_LEN = RDMA_LENGTH_WIDTH'(MAX_BURST_BYTES);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef struct packed {
`ifdef RX_RKEY_CHECK_EN
    logic [RDMA_RKEY_WIDTH-1:0]   rkey;
`endif
    logic [7:0]                   opcode;
    logic [RDMA_LENGTH_WIDTH-1:0] length;
    logic [C_ADDR_WIDTH-1:0]      addr;
  } hdr_t;

  state_t                       state_q;
  logic [C_ADDR_WIDTH-1:0]      addr_q;
  logic [RDMA_LENGTH_WIDTH-1:0] remaining_q;
  logic [7:0]                   opcode_q;
  logic [3:0]                   tag_q;
  logic [3:0]                   outstanding_q;
  logic [15:0]                  flags_q, flags_d;
  logic [3:0]                   flag_wr_idx;
  logic                         overflow_q;

  hdr_t                         fifo_mem [HDR_FIFO_DEPTH];
  hdr_t                         hdr_in;
  hdr_t                         hdr_head;
  logic [FIFO_AW:0]             wr_ptr_q, rd_ptr_q;
  logic                         fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic                         opcode_ok, rkey_bad, drop;
  logic                         last_chunk, cmd_hs, cmplt_ok;
  logic [C_BTT_WIDTH-1:0]       btt;

  // Upper remote-address bits are outside the DDR window by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^rdma_remote_addr[RDMA_ADDR_WIDTH-1:C_ADDR_WIDTH];

  // --------------------------------------------------------------------------
  // Header FIFO
  // --------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    hdr_in        = '0;
    hdr_in.addr   = rdma_remote_addr[C_ADDR_WIDTH-1:0] + C_ADDR_WIDTH'(fragment_offset);
    hdr_in.length = rdma_length;
    hdr_in.opcode = rdma_opcode;
`ifdef RX_RKEY_CHECK_EN
    hdr_in.rkey   = rdma_rkey;
`endif
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                      (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  // A full FIFO still takes a push when the FSM frees a slot in the same cycle.
  assign fifo_push  = header_valid && (!fifo_full || fifo_pop);
  assign hdr_head   = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge aclk) begin
    if (fifo_push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= hdr_in;
  end

  // NOTE: sequential state is always updated with non-blocking assignments to avoid simulation races.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
      overflow_q <= header_valid && !fifo_push;
    end
  end

  // --------------------------------------------------------------------------
  // Header validation
  // --------------------------------------------------------------------------
  always_comb begin
    opcode_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (opcode_q == WRITE_OPCODES[i]) opcode_ok = 1'b1;
    end
  end

`ifdef RX_RKEY_CHECK_EN
  logic [RDMA_RKEY_WIDTH-1:0] rkey_q;
  assign rkey_bad = (rkey_q != local_rkey);
`else
  logic unused_rkey_inputs;
  assign unused_rkey_inputs = ^{rdma_rkey, local_rkey};
  assign rkey_bad = 1'b0;
`endif

  assign drop = !opcode_ok || (remaining_q == '0) || rkey_bad;

  // --------------------------------------------------------------------------
  // Command generation
  // --------------------------------------------------------------------------
  assign last_chunk = (remaining_q <= MAX_BURST_LEN);
  assign btt        = last_chunk ? C_BTT_WIDTH'(remaining_q) : C_BTT_WIDTH'(MAX_BURST_BYTES);
  assign cmd_hs     = m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready;
  assign cmplt_ok   = s2mm_wr_xfer_cmplt && (outstanding_q != 4'd0);

  // Credit only falls while ISSUE waits, so tvalid cannot drop before its handshake.
  assign m_axis_s2mm_cmd_tvalid = (state_q == ST_ISSUE) && (outstanding_q < MAX_OUT);
  assign m_axis_s2mm_cmd_tdata  = (state_q == ST_ISSUE) ?
      {4'h0, tag_q, addr_q, 1'b0, last_chunk, 6'h00, 1'b1, btt} : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      opcode_q    <= '0;
      tag_q       <= '0;
`ifdef RX_RKEY_CHECK_EN
      rkey_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            addr_q      <= hdr_head.addr;
            remaining_q <= hdr_head.length;
            opcode_q    <= hdr_head.opcode;
`ifdef RX_RKEY_CHECK_EN
            rkey_q      <= hdr_head.rkey;
`endif
            state_q     <= ST_CHECK;
          end
        end
        ST_CHECK: state_q <= drop ? ST_IDLE : ST_ISSUE;
        ST_ISSUE: begin
          if (cmd_hs) begin
            addr_q      <= addr_q + C_ADDR_WIDTH'(btt);
            remaining_q <= remaining_q - RDMA_LENGTH_WIDTH'(btt);
            tag_q       <= tag_q + 4'd1;
            if (last_chunk) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Completion tracking: flags_q[0] is the eof flag of the oldest in-flight command.
  // --------------------------------------------------------------------------
  assign flag_wr_idx = outstanding_q - {3'b000, cmplt_ok};

  always_comb begin
    flags_d = flags_q;
    if (cmplt_ok) flags_d = flags_q >> 1;
    if (cmd_hs)   flags_d[flag_wr_idx] = last_chunk;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding_q <= '0;
      flags_q       <= '0;
    end else begin
      flags_q <= flags_d;
      case ({cmd_hs, cmplt_ok})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  assign rx_state       = state_q;
  assign outstanding    = outstanding_q;
  assign rx_active      = (state_q != ST_IDLE) || (outstanding_q != 4'd0);
  assign write_accepted = (state_q == ST_CHECK) && !drop;
  assign hdr_dropped    = (state_q == ST_CHECK) && drop;
  assign rkey_error     = (state_q == ST_CHECK) && rkey_bad;
  assign write_complete = cmplt_ok && flags_q[0];
  assign hdr_overflow   = overflow_q;

endmodule

// File: tb/tb_rx_write_scheduler.sv
// Scoreboard bench for rx_write_scheduler: stimulus queues expected commands and status events,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_rx_write_scheduler;
  localparam int CW = 72;

  typedef enum int {EV_ACC = 0, EV_DROP = 1, EV_RKERR = 2, EV_CMPL = 3, EV_OVF = 4} ev_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          header_valid = 1'b0;
  logic [7:0]    rdma_opcode = '0;
  logic [63:0]   rdma_remote_addr = '0;
  logic [31:0]   rdma_rkey = '0;
  logic [31:0]   rdma_length = '0;
  logic [15:0]   fragment_offset = '0;
  logic [31:0]   local_rkey = 32'h0000_BEEF;
  logic [CW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          cmplt = 1'b0;
  logic [1:0]    rx_state;
  logic          rx_active;
  logic [3:0]    outstanding;
  logic          write_accepted, write_complete, hdr_dropped, hdr_overflow, rkey_error;

  rx_write_scheduler dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .header_valid           (header_valid),
    .rdma_opcode            (rdma_opcode),
    .rdma_remote_addr       (rdma_remote_addr),
    .rdma_rkey              (rdma_rkey),
    .rdma_length            (rdma_length),
    .fragment_offset        (fragment_offset),
    .local_rkey             (local_rkey),
    .m_axis_s2mm_cmd_tdata  (tdata),
    .m_axis_s2mm_cmd_tvalid (tvalid),
    .m_axis_s2mm_cmd_tready (tready),
    .s2mm_wr_xfer_cmplt     (cmplt),
    .rx_state               (rx_state),
    .rx_active              (rx_active),
    .outstanding            (outstanding),
    .write_accepted         (write_accepted),
    .write_complete         (write_complete),
    .hdr_dropped            (hdr_dropped),
    .hdr_overflow           (hdr_overflow),
    .rkey_error             (rkey_error)
  );

  always #5 aclk = ~aclk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [CW-1:0] cmd_q[$];
  ev_t           ev_q[$];
  int            hs_log[$];
  logic [3:0]    exp_tag = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                            input logic eof, input logic [22:0] btt);
    return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, btt};
  endfunction

  task automatic exp_cmd(input logic [31:0] addr, input logic eof, input int btt);
    cmd_q.push_back(mk_cmd(exp_tag, addr, eof, 23'(btt)));
    exp_tag = exp_tag + 4'd1;
  endtask

  task automatic ev_seen(input ev_t got);
    n_cmp++;
    if (ev_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got unexpected event %0d at cycle %0d, expected none", int'(got), cyc);
    end else begin
      ev_t exp;
      exp = ev_q.pop_front();
      if (got != exp) begin
        n_err++;
        $display("FAIL event: got event %0d at cycle %0d, expected %0d", int'(got), cyc, int'(exp));
      end
    end
  endtask

  // Monitor: compares commands at handshake and status pulses in a fixed per-cycle order.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (tvalid && tready) begin
        hs_log.push_back(cyc);
        if (cmd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cmd: got unexpected command %0h, expected none", tdata);
        end else begin
          check("cmd", tdata, cmd_q.pop_front());
        end
      end
      if (write_accepted) ev_seen(EV_ACC);
      if (hdr_dropped)    ev_seen(EV_DROP);
      if (rkey_error)     ev_seen(EV_RKERR);
      if (write_complete) ev_seen(EV_CMPL);
      if (hdr_overflow)   ev_seen(EV_OVF);
    end
  end

  task automatic send_hdr(input logic [7:0] op, input logic [63:0] addr, input logic [31:0] rkey,
                          input logic [31:0] len, input logic [15:0] off);
    @(posedge aclk); #1;
    header_valid = 1'b1;
    rdma_opcode = op;
    rdma_remote_addr = addr;
    rdma_rkey = rkey;
    rdma_length = len;
    fragment_offset = off;
    @(posedge aclk); #1;
    header_valid = 1'b0;
  endtask

  task automatic pulse_cmplt(input bit expect_complete);
    @(posedge aclk); #1;
    if (expect_complete) ev_q.push_back(EV_CMPL);
    cmplt = 1'b1;
    @(posedge aclk); #1;
    cmplt = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || cmd_q.size() != 0) && n < 300) begin
      @(posedge aclk);
      n++;
    end
    n_cmp++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d events / %0d commands pending, expected 0", name,
               ev_q.size(), cmd_q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tdata"}, tdata, '0);
    check({name, "_tvalid"}, CW'(tvalid), '0);
    check({name, "_state"}, CW'(rx_state), '0);
    check({name, "_active"}, CW'(rx_active), '0);
    check({name, "_outstanding"}, CW'(outstanding), '0);
    check({name, "_pulses"},
          CW'({write_accepted, write_complete, hdr_dropped, hdr_overflow, rkey_error}), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] held;
    bit            stable;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Single message with latency checks
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h1000_0020, 1'b1, 100);
    send_hdr(8'h0A, 64'h1000_0000, 32'h0, 32'd100, 16'h0020);
    @(negedge aclk);
    check("lat_idle", CW'(rx_state), CW'(2'd0));
    @(negedge aclk);
    check("lat_check", CW'(rx_state), CW'(2'd1));
    check("lat_accepted", CW'(write_accepted), CW'(1'b1));
    @(negedge aclk);
    check("lat_tvalid", CW'(tvalid), CW'(1'b1));
    wait_idle("single");
    check("single_outstanding", CW'(outstanding), CW'(4'd1));
    check("single_active", CW'(rx_active), CW'(1'b1));
    pulse_cmplt(1'b1);
    wait_idle("single_cmplt");
    check("single_done_outstanding", CW'(outstanding), CW'(4'd0));
    check("single_done_active", CW'(rx_active), CW'(1'b0));

    // Splitting into back-to-back chunks
    hs_log.delete();
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h2000_0000, 1'b0, 4096);
    exp_cmd(32'h2000_1000, 1'b0, 4096);
    exp_cmd(32'h2000_2000, 1'b1, 1808);
    send_hdr(8'h07, 64'h2000_0000, 32'h0, 32'd10000, 16'h0000);
    wait_idle("split");
    check("split_b2b", CW'(hs_log[2] - hs_log[0]), CW'(2));
    check("split_outstanding", CW'(outstanding), CW'(4'd3));
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b1);
    wait_idle("split_cmplt");

    // Credit limit, backpressure and coincident handshake/completion
    ev_q.push_back(EV_ACC);
    for (int i = 0; i < 8; i++) exp_cmd(32'h3000_0000 + 32'(i) * 32'h1000, (i == 7), 4096);
    send_hdr(8'h06, 64'h3000_0000, 32'h0, 32'd32768, 16'h0000);
    repeat (12) @(posedge aclk);
    @(negedge aclk);
    check("credit_pending", CW'(cmd_q.size()), CW'(4));
    check("credit_tvalid", CW'(tvalid), CW'(1'b0));
    check("credit_outstanding", CW'(outstanding), CW'(4'd4));
    pulse_cmplt(1'b0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("credit_fifth", CW'(cmd_q.size()), CW'(3));
    check("credit_refill", CW'(outstanding), CW'(4'd4));
    tready = 1'b0;
    pulse_cmplt(1'b0);
    @(negedge aclk);
    held = tdata;
    stable = tvalid;
    repeat (10) begin
      @(negedge aclk);
      stable &= (tvalid === 1'b1) && (tdata === held);
    end
    check("bp_stable", CW'(stable), CW'(1'b1));
    check("bp_value", held, cmd_q[0]);
    @(posedge aclk); #1;
    tready = 1'b1;
    cmplt = 1'b1;
    @(posedge aclk); #1;
    cmplt = 1'b0;
    @(negedge aclk);
    check("coincident_outstanding", CW'(outstanding), CW'(4'd3));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("credit_last_wait", CW'(cmd_q.size()), CW'(1));
    check("credit_full_again", CW'(outstanding), CW'(4'd4));
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b1);
    wait_idle("credit_cmplt");
    check("credit_done", CW'(outstanding), CW'(4'd0));

    // Drops and boundary length
    ev_q.push_back(EV_DROP);
    send_hdr(8'h11, 64'h4000_0000, 32'h0, 32'd100, 16'h0000);
    wait_idle("bad_opcode");
    ev_q.push_back(EV_DROP);
    send_hdr(8'h06, 64'h4000_0000, 32'h0, 32'd0, 16'h0000);
    wait_idle("zero_len");
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h6000_0000, 1'b1, 4096);
    send_hdr(8'h08, 64'h6000_0000, 32'h0, 32'd4096, 16'h0000);
    wait_idle("exact_burst");
    pulse_cmplt(1'b1);
    wait_idle("exact_burst_cmplt");

    // rkey handling
`ifdef RX_RKEY_CHECK_EN
    ev_q.push_back(EV_DROP);
    ev_q.push_back(EV_RKERR);
    send_hdr(8'h0A, 64'h7000_0000, 32'h0000_DEAD, 32'd64, 16'h0000);
    wait_idle("rkey_bad");
`else
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h7000_0000, 1'b1, 64);
    send_hdr(8'h0A, 64'h7000_0000, 32'h0000_DEAD, 32'd64, 16'h0000);
    wait_idle("rkey_ignored");
    pulse_cmplt(1'b1);
    wait_idle("rkey_ignored_cmplt");
`endif

    // FIFO overflow while the FSM is stalled in ISSUE
    tready = 1'b0;
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h4000_0000, 1'b1, 64);
    send_hdr(8'h07, 64'h4000_0000, 32'h0, 32'd64, 16'h0000);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("ovf_stalled", CW'(rx_state), CW'(2'd2));
    ev_q.push_back(EV_OVF);
    for (int i = 0; i < 8; i++) ev_q.push_back(EV_DROP);
    @(posedge aclk); #1;
    for (int i = 0; i < 9; i++) begin
      header_valid = 1'b1;
      rdma_opcode = 8'h11;
      rdma_length = 32'd1;
      @(posedge aclk); #1;
    end
    header_valid = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("ovf_seen", CW'(ev_q.size()), CW'(8));
    tready = 1'b1;
    wait_idle("ovf_drain");
    pulse_cmplt(1'b1);
    wait_idle("ovf_cmplt");

    // Reset during ISSUE with credits exhausted
    ev_q.push_back(EV_ACC);
    for (int i = 0; i < 4; i++) exp_cmd(32'h5000_0000 + 32'(i) * 32'h1000, 1'b0, 4096);
    send_hdr(8'h08, 64'h5000_0000, 32'h0, 32'd32768, 16'h0000);
    repeat (12) @(posedge aclk);
    @(negedge aclk);
    check("rst_pre_state", CW'(rx_state), CW'(2'd2));
    check("rst_pre_outstanding", CW'(outstanding), CW'(4'd4));
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(negedge aclk);
    check_all_zero("midreset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    exp_tag = '0;
    pulse_cmplt(1'b0);
    @(negedge aclk);
    check("late_cmplt_outstanding", CW'(outstanding), CW'(4'd0));

    // Post-reset message: tag restarts, address wraps, one byte over a burst
    ev_q.push_back(EV_ACC);
    exp_cmd(32'h0000_0010, 1'b0, 4096);
    exp_cmd(32'h0000_1010, 1'b1, 1);
    send_hdr(8'h01, 64'h1234_5678_FFFF_FFF0, 32'h0, 32'd4097, 16'h0020);
    wait_idle("wrap");
    pulse_cmplt(1'b0);
    pulse_cmplt(1'b1);
    wait_idle("wrap_cmplt");
    check("end_events", CW'(ev_q.size()), CW'(0));
    check("end_cmds", CW'(cmd_q.size()), CW'(0));
    check("end_active", CW'(rx_active), CW'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
